// File: rtl/axi4_lite_bram_bridge_p.sv
// AXI4-Lite slave to single-port BRAM bridge: one-entry AW/W/AR holding registers,
// write/read round-robin, address-window decode with SLVERR and a saturating error count.
module axi4_lite_bram_bridge_p #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                BRAM_ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RD_LAT      = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   AW_VALID,
  output logic                   AW_READY,
  input  logic [ADDR_W-1:0]      AW_ADDR,
  input  logic                   W_VALID,
  output logic                   W_READY,
  input  logic [DATA_W-1:0]      W_DATA,
  input  logic [DATA_W/8-1:0]    W_STRB,
  output logic                   B_VALID,
  input  logic                   B_READY,
  output logic [1:0]             B_RESP,
  input  logic                   AR_VALID,
  output logic                   AR_READY,
  input  logic [ADDR_W-1:0]      AR_ADDR,
  output logic                   R_VALID,
  input  logic                   R_READY,
  output logic [DATA_W-1:0]      R_DATA,
  output logic [1:0]             R_RESP,
  output logic                   SLAVE_EN,
  output logic [DATA_W/8-1:0]    SLAVE_WE,
  output logic [BRAM_ADDR_W-1:0] SLAVE_ADDR,
  output logic [DATA_W-1:0]      SLAVE_DIN,
  input  logic [DATA_W-1:0]      SLAVE_DOUT,
  output logic [7:0]             ERR_COUNT
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [ADDR_W:0] WIN_BYTES = {{ADDR_W{1'b0}}, 1'b1} << (OFF_W + BRAM_ADDR_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;

  logic                aw_full, w_full, ar_full;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [RD_LAT-1:0]   pipe_v, pipe_e;
  grant_e              last_grant, last_grant_d;
  logic                wr_elig, rd_elig, issue_wr, issue_rd;
  logic [ADDR_W-1:0]   aw_off, ar_off;
  logic                aw_in, ar_in;
  logic                b_valid, r_valid;
  logic [1:0]          b_resp, r_resp;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          err_count;

  // Unsigned wrap pushes addresses below BASE_ADDR far above the window.
  assign aw_off = aw_addr_q - BASE_ADDR;
  assign ar_off = ar_addr_q - BASE_ADDR;
  assign aw_in  = {1'b0, aw_off} < WIN_BYTES;
  assign ar_in  = {1'b0, ar_off} < WIN_BYTES;

  assign AW_READY  = ~aw_full;
  assign W_READY   = ~w_full;
  assign AR_READY  = ~ar_full;
  assign B_VALID   = b_valid;
  assign B_RESP    = b_resp;
  assign R_VALID   = r_valid;
  assign R_DATA    = r_data;
  assign R_RESP    = r_resp;
  assign ERR_COUNT = err_count;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    wr_elig      = aw_full & w_full & ~b_valid;
    rd_elig      = ar_full & ~(|pipe_v) & ~r_valid;
    issue_wr     = wr_elig & (~rd_elig | (last_grant == GNT_RD));
    issue_rd     = rd_elig & ~issue_wr;
    last_grant_d = last_grant;
    SLAVE_EN     = 1'b0;
    SLAVE_WE     = '0;
    SLAVE_ADDR   = '0;
    SLAVE_DIN    = '0;
    if (issue_wr) begin
      last_grant_d = GNT_WR;
      if (aw_in) begin
        SLAVE_EN   = 1'b1;
        SLAVE_WE   = w_strb_q;
        SLAVE_ADDR = aw_off[OFF_W +: BRAM_ADDR_W];
        SLAVE_DIN  = w_data_q;
      end
    end else if (issue_rd) begin
      last_grant_d = GNT_RD;
      if (ar_in) begin
        SLAVE_EN   = 1'b1;
        SLAVE_ADDR = ar_off[OFF_W +: BRAM_ADDR_W];
      end
    end
  end

  // NOTE: payload registers carry no reset; the full flags alone say whether they hold anything.
  always_ff @(posedge ACLK) begin
    if (AW_VALID && !aw_full) aw_addr_q <= AW_ADDR;
    if (W_VALID && !w_full) begin
      w_data_q <= W_DATA;
      w_strb_q <= W_STRB;
    end
    if (AR_VALID && !ar_full) ar_addr_q <= AR_ADDR;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      ar_full    <= 1'b0;
      pipe_v     <= '0;
      pipe_e     <= '0;
      last_grant <= GNT_RD;
      b_valid    <= 1'b0;
      b_resp     <= RESP_OKAY;
      r_valid    <= 1'b0;
      r_resp     <= RESP_OKAY;
      r_data     <= '0;
      err_count  <= '0;
    end else begin
      last_grant <= last_grant_d;

      if (AW_VALID && !aw_full) aw_full <= 1'b1;
      else if (issue_wr)        aw_full <= 1'b0;
      if (W_VALID && !w_full)   w_full  <= 1'b1;
      else if (issue_wr)        w_full  <= 1'b0;
      if (AR_VALID && !ar_full) ar_full <= 1'b1;
      else if (issue_rd)        ar_full <= 1'b0;

      if (issue_wr) begin
        b_valid <= 1'b1;
        b_resp  <= aw_in ? RESP_OKAY : RESP_SLVERR;
      end else if (b_valid && B_READY) begin
        b_valid <= 1'b0;
      end

      pipe_v[0] <= issue_rd;
      pipe_e[0] <= issue_rd & ~ar_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end

      // The last pipe stage lines up with SLAVE_DOUT for the issued address.
      if (pipe_v[RD_LAT-1]) begin
        r_valid <= 1'b1;
        r_data  <= pipe_e[RD_LAT-1] ? '0 : SLAVE_DOUT;
        r_resp  <= pipe_e[RD_LAT-1] ? RESP_SLVERR : RESP_OKAY;
      end else if (r_valid && R_READY) begin
        r_valid <= 1'b0;
      end

      if (((issue_wr && !aw_in) || (issue_rd && !ar_in)) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_bram_bridge_p.sv
// Self-checking bench for axi4_lite_bram_bridge_p: directed scenarios, then random
// traffic scored against an address-map/memory reference model.
module tb_axi4_lite_bram_bridge_p;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam logic [31:0] WIN  = 32'h0000_0400;

  logic        ACLK, ARESETn;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic        AR_VALID, AR_READY, R_VALID, R_READY, SLAVE_EN;
  logic [31:0] AW_ADDR, AR_ADDR, W_DATA, R_DATA, SLAVE_DIN, SLAVE_DOUT;
  logic [3:0]  W_STRB, SLAVE_WE;
  logic [1:0]  B_RESP, R_RESP;
  logic [7:0]  SLAVE_ADDR, ERR_COUNT;

  axi4_lite_bram_bridge_p #(
    .DATA_W(32), .ADDR_W(32), .BRAM_ADDR_W(8), .BASE_ADDR(BASE), .RD_LAT(2)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .SLAVE_EN(SLAVE_EN), .SLAVE_WE(SLAVE_WE), .SLAVE_ADDR(SLAVE_ADDR),
    .SLAVE_DIN(SLAVE_DIN), .SLAVE_DOUT(SLAVE_DOUT), .ERR_COUNT(ERR_COUNT)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Two-cycle BRAM: data for an enabled address appears on SLAVE_DOUT two cycles later.
  logic [31:0] bram [0:255];
  logic [31:0] rd1, rd2;
  always @(posedge ACLK) begin
    if (SLAVE_EN) begin
      for (int b = 0; b < 4; b++)
        if (SLAVE_WE[b]) bram[SLAVE_ADDR][8*b +: 8] <= SLAVE_DIN[8*b +: 8];
      rd1 <= bram[SLAVE_ADDR];
    end
    rd2 <= rd1;
  end
  assign SLAVE_DOUT = rd2;

  int en_count = 0;
  always @(negedge ACLK) if (SLAVE_EN === 1'b1) en_count++;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [0:255];
  int  ref_err = 0;
  bit  model_last_rd = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + WIN);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic note_err();
    if (ref_err < 255) ref_err++;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx_of(a)][8*b +: 8] = d[8*b +: 8];
    end else note_err();
    model_last_rd = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_resp);
    int n;
    n = 0;
    B_READY = 1'b1;
    while (!B_VALID && n < 50) begin tick(); n++; end
    check("b_valid_seen", B_VALID, 1);
    check("b_resp", B_RESP, exp_resp);
    tick();
    B_READY = 1'b0;
  endtask

  task automatic wait_r(input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    n = 0;
    R_READY = 1'b1;
    while (!R_VALID && n < 50) begin tick(); n++; end
    check("r_valid_seen", R_VALID, 1);
    check("r_data", R_DATA, exp_data);
    check("r_resp", R_RESP, exp_resp);
    tick();
    R_READY = 1'b0;
  endtask

  // W is presented first; AW follows 'lead' cycles later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    W_DATA = d; W_STRB = s; W_VALID = 1'b1;
    AW_ADDR = a; AW_VALID = (lead == 0);
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = AW_VALID && AW_READY;
      w_hs  = W_VALID && W_READY;
      tick(); n++;
      if (aw_hs) begin aw_done = 1; AW_VALID = 1'b0; end
      if (w_hs)  begin w_done  = 1; W_VALID  = 1'b0; end
      if (!aw_done && n >= lead) AW_VALID = 1'b1;
    end
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    model_write(a, d, s);
    wait_b(in_rng(a) ? 2'b00 : 2'b10);
  endtask

  task automatic do_read(input logic [31:0] a);
    int n;
    n = 0;
    AR_ADDR = a; AR_VALID = 1'b1;
    while (!AR_READY && n < 50) begin tick(); n++; end
    tick();
    AR_VALID = 1'b0;
    model_last_rd = 1'b1;
    if (in_rng(a)) wait_r(ref_mem[idx_of(a)], 2'b00);
    else begin
      note_err();
      wait_r(32'h0, 2'b10);
    end
  endtask

  function automatic logic [31:0] rand_oor();
    logic [31:0] a;
    a = $urandom;
    while (in_rng(a)) a = $urandom;
    return a;
  endfunction

  initial begin
    logic [31:0] a, a2, d, d2;
    logic [3:0]  s;
    bit          exp_w, got_b, got_r;
    int          n, e0, rv_seen;

    for (int i = 0; i < 256; i++) begin bram[i] = '0; ref_mem[i] = '0; end
    ARESETn = 1'b0;
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0; B_READY = 0; R_READY = 0;
    AW_ADDR = '0; AR_ADDR = '0; W_DATA = '0; W_STRB = '0;
    tick(); tick();
    check("rst_b_valid", B_VALID, 0);
    check("rst_r_valid", R_VALID, 0);
    check("rst_r_data", R_DATA, 0);
    check("rst_err", ERR_COUNT, 0);
    check("rst_en", SLAVE_EN, 0);
    check("rst_aw_ready", AW_READY, 1);
    ARESETn = 1'b1;
    tick();

    // Write 0xDEADBEEF at BASE+0x10, then read it back with exact latencies.
    AW_ADDR = BASE + 32'h10; AW_VALID = 1; W_DATA = 32'hDEAD_BEEF; W_STRB = 4'hF; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    check("t1_wr_en", SLAVE_EN, 1);
    check("t1_wr_addr", SLAVE_ADDR, 4);
    check("t1_wr_we", SLAVE_WE, 4'hF);
    check("t1_wr_din", SLAVE_DIN, 32'hDEAD_BEEF);
    model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    check("t1_b_next_cycle", B_VALID, 1);
    check("t1_b_resp", B_RESP, 0);
    B_READY = 1; tick(); B_READY = 0;
    check("t1_b_cleared", B_VALID, 0);
    AR_ADDR = BASE + 32'h10; AR_VALID = 1;
    tick();
    AR_VALID = 0;
    check("t1_rd_en", SLAVE_EN, 1);
    check("t1_rd_we", SLAVE_WE, 0);
    check("t1_rd_addr", SLAVE_ADDR, 4);
    model_last_rd = 1'b1;
    n = 0;
    while (!R_VALID && n < 20) begin tick(); n++; end
    check("t1_r_latency", n, 3);
    check("t1_r_data", R_DATA, ref_mem[4]);
    check("t1_r_resp", R_RESP, 0);
    R_READY = 1; tick(); R_READY = 0;
    check("t1_r_cleared", R_VALID, 0);

    // W three cycles ahead of AW, partial strobe.
    W_DATA = 32'h0000_A5A5; W_STRB = 4'h3; W_VALID = 1;
    tick();
    W_VALID = 0;
    check("t2_w_ready_drop", W_READY, 0);
    check("t2_no_early_issue", SLAVE_EN, 0);
    tick();
    tick();
    AW_ADDR = BASE + 32'h8; AW_VALID = 1;
    check("t2_w_still_held", W_READY, 0);
    tick();
    AW_VALID = 0;
    check("t2_issue_en", SLAVE_EN, 1);
    check("t2_issue_we", SLAVE_WE, 4'h3);
    check("t2_issue_addr", SLAVE_ADDR, 2);
    check("t2_issue_din", SLAVE_DIN, 32'h0000_A5A5);
    e0 = en_count;
    tick();
    check("t2_single_issue", SLAVE_EN, 0);
    check("t2_w_ready_back", W_READY, 1);
    model_write(BASE + 32'h8, 32'h0000_A5A5, 4'h3);
    wait_b(2'b00);
    check("t2_issue_count", en_count - e0, 1);
    do_read(BASE + 32'h8);

    // Four ties; a solo op of the winner's kind in between flips the next tie.
    for (int r = 0; r < 4; r++) begin
      a = BASE + 32'((16 + r) * 4);
      d = $urandom;
      AW_ADDR = a; W_DATA = d; W_STRB = 4'hF; AR_ADDR = BASE + 32'h10;
      AW_VALID = 1; W_VALID = 1; AR_VALID = 1;
      tick();
      AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
      exp_w = model_last_rd;
      check("t3_tie_winner_is_wr", SLAVE_WE != 0, exp_w);
      check("t3_tie_en", SLAVE_EN, 1);
      check("t3_tie_addr", SLAVE_ADDR, exp_w ? 32'(16 + r) : 32'd4);
      tick();
      check("t3_loser_is_wr", SLAVE_WE != 0, !exp_w);
      check("t3_loser_en", SLAVE_EN, 1);
      check("t3_loser_addr", SLAVE_ADDR, exp_w ? 32'd4 : 32'(16 + r));
      model_write(a, d, 4'hF);
      model_last_rd = exp_w;
      got_b = 0; got_r = 0; n = 0;
      B_READY = 1; R_READY = 1;
      while (!(got_b && got_r) && n < 30) begin
        if (B_VALID && !got_b) begin got_b = 1; check("t3_b_resp", B_RESP, 0); end
        if (R_VALID && !got_r) begin
          got_r = 1;
          check("t3_r_data", R_DATA, ref_mem[4]);
          check("t3_r_resp", R_RESP, 0);
        end
        tick(); n++;
      end
      B_READY = 0; R_READY = 0;
      check("t3_both_done", {got_b, got_r}, 2'b11);
      if (exp_w) do_write(BASE + 32'h40, $urandom, 4'hF, 0);
      else       do_read(BASE + 32'h10);
    end

    // First address past the window, then saturate the error counter.
    e0 = en_count;
    do_read(BASE + WIN);
    check("t4_no_bram_access", en_count - e0, 0);
    check("t4_err_one", ERR_COUNT, ref_err);
    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 0) ? rand_oor() : (BASE - 32'h4 - 32'(i));
      do_write(a, $urandom, 4'hF, 0);
    end
    check("t4_err_saturated", ERR_COUNT, ref_err);
    check("t4_no_bram_access_wr", en_count - e0, 0);

    // B held for five cycles while a second write waits in the holding registers.
    a = rand_oor(); a2 = BASE + 32'h20; d2 = $urandom;
    AW_ADDR = a; W_DATA = 32'h1234_5678; W_STRB = 4'hF; AW_VALID = 1; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    check("t5_oor_no_en", SLAVE_EN, 0);
    model_write(a, 32'h1234_5678, 4'hF);
    tick();
    check("t5_b_valid", B_VALID, 1);
    check("t5_b_resp", B_RESP, 2);
    AW_ADDR = a2; W_DATA = d2; W_STRB = 4'hF; AW_VALID = 1; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    check("t5_aw_captured", AW_READY, 0);
    check("t5_w_captured", W_READY, 0);
    for (int k = 0; k < 4; k++) begin
      check("t5_b_held", B_VALID, 1);
      check("t5_resp_held", B_RESP, 2);
      check("t5_no_issue", SLAVE_EN, 0);
      if (k == 3) B_READY = 1;
      tick();
    end
    check("t5_b_cleared", B_VALID, 0);
    check("t5_second_issue", SLAVE_EN, 1);
    check("t5_second_addr", SLAVE_ADDR, 8);
    check("t5_second_din", SLAVE_DIN, d2);
    model_write(a2, d2, 4'hF);
    tick();
    check("t5_second_b", B_VALID, 1);
    check("t5_second_resp", B_RESP, 0);
    tick();
    B_READY = 0;
    do_read(a2);

    // Reset lands the cycle after a read issue.
    AR_ADDR = BASE + 32'h10; AR_VALID = 1;
    tick();
    AR_VALID = 0;
    check("t6_rd_issue", SLAVE_EN, 1);
    ARESETn = 0;
    tick();
    ARESETn = 1;
    ref_err = 0;
    model_last_rd = 1'b1;
    check("t6_b_valid", B_VALID, 0);
    check("t6_r_valid", R_VALID, 0);
    check("t6_r_data", R_DATA, 0);
    check("t6_r_resp", R_RESP, 0);
    check("t6_b_resp", B_RESP, 0);
    check("t6_err", ERR_COUNT, 0);
    check("t6_en", SLAVE_EN, 0);
    check("t6_we", SLAVE_WE, 0);
    check("t6_ar_ready", AR_READY, 1);
    rv_seen = 0;
    R_READY = 1;
    repeat (6) begin tick(); if (R_VALID) rv_seen++; end
    R_READY = 0;
    check("t6_no_r_beat", rv_seen, 0);
    do_read(BASE + 32'h10);

    // Random traffic against the reference memory and error count.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = rand_oor();
      else a = BASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(0, 15));
        do_write(a, $urandom, s, $urandom_range(0, 3));
      end else begin
        do_read(a);
      end
      check("rnd_err_count", ERR_COUNT, ref_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_lite_bram_bridge_p.md
Name: axi4_lite_bram_bridge_p

Overview:
- Parametrised AXI4-Lite slave to single-port BRAM bridge. Successor to the fixed 32-bit, 1-cycle-latency bus bridge.
- Adds:
  - configurable data width, address window and BRAM read latency
  - fair round-robin arbitration between write and read
  - address-range decode with SLVERR response
  - saturating error counter
- Sits between the CPU/DMA AXI4-Lite master and one BRAM bank.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, one of 32/64.
- ADDR_W, 32, AXI address width.
- BRAM_ADDR_W, 12, BRAM word-address width.
- BASE_ADDR, 0, byte base address of the BRAM window; aligned to window size.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1..3.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- AW_VALID in 1; AW_READY out 1; AW_ADDR in ADDR_W  — write address channel
- W_VALID in 1; W_READY out 1; W_DATA in DATA_W; W_STRB in DATA_W/8  — write data channel
- B_VALID out 1; B_READY in 1; B_RESP out 2  — write response
- AR_VALID in 1; AR_READY out 1; AR_ADDR in ADDR_W  — read address channel
- R_VALID out 1; R_READY in 1; R_DATA out DATA_W; R_RESP out 2  — read data
- SLAVE_EN  out  1  BRAM enable, high in the issue cycle only
- SLAVE_WE  out  DATA_W/8  byte write enables
- SLAVE_ADDR  out  BRAM_ADDR_W  BRAM word address
- SLAVE_DIN  out  DATA_W  BRAM write data
- SLAVE_DOUT  in  DATA_W  BRAM read data, valid RD_LAT cycles after the issue cycle
- ERR_COUNT  out  8  saturating count of SLVERR responses

Behaviour:
- Reset (ARESETn low at a rising edge):
  - All holding flags, the read pipeline and the arbiter clear.
  - B_VALID=0, R_VALID=0, R_DATA=0, B_RESP=R_RESP=0, ERR_COUNT=0.
  - SLAVE_EN=0, SLAVE_WE=0.
  - An in-flight read is discarded with no R beat.
  - Last-grant state resets to "read", so write wins the first tie.
- AW and W each have a one-entry holding register, so they can arrive in either order and in any cycles.
  - AW_READY = ~aw_full; W_READY = ~w_full.
  - On a handshake, capture the address, or the data and strobe.
- AR holding register: AR_READY = ~ar_full.
- Word index is ADDR[log2(DATA_W/8)+BRAM_ADDR_W-1 : log2(DATA_W/8)] of (ADDR - BASE_ADDR). Low byte-offset bits are ignored.
- In range means BASE_ADDR <= ADDR < BASE_ADDR + (DATA_W/8)*2^BRAM_ADDR_W.
- Write eligible when aw_full & w_full & ~B_VALID.
- Read eligible when ar_full & read pipe empty & ~R_VALID.
- Arbiter, combinational, at most one issue per cycle:
  - If only one request is eligible, grant it.
  - If both are eligible, grant the opposite of the last grant.
  - Update last-grant on every issue.
- Write issue cycle:
  - In range: SLAVE_EN=1, SLAVE_WE=strobe, SLAVE_ADDR=index, SLAVE_DIN=data.
  - Out of range: SLAVE_EN=0, SLAVE_WE=0.
  - aw_full and w_full clear at the next edge.
  - Next cycle: B_VALID=1, B_RESP=00 (in range) or 10 (SLVERR).
  - B_VALID holds until B_READY; it clears at the edge where B_VALID&B_READY.
- Read issue cycle at T:
  - In range: SLAVE_EN=1, SLAVE_WE=0, SLAVE_ADDR=index.
  - ar_full clears at the next edge.
  - A shift pipeline of RD_LAT stages carries {valid, err}.
  - SLAVE_DOUT is sampled at the end of cycle T+RD_LAT.
  - R_VALID=1 from cycle T+RD_LAT+1 with R_DATA=SLAVE_DOUT and R_RESP=00.
  - If out of range: no BRAM enable, same latency, R_DATA=0, R_RESP=10.
  - R_VALID, R_DATA and R_RESP hold stable until R_READY.
- Only one read is outstanding at a time.
  - A new AR may be accepted into the holding register while a read is in flight.
  - That read issues only after R_VALID&R_READY.
- No-issue cycle: SLAVE_EN=0, SLAVE_WE=0, SLAVE_ADDR=0, SLAVE_DIN=0.
- ERR_COUNT increments by 1 on each SLVERR issue and saturates at 255.
- W_STRB=0 with an in-range address:
  - The issue still occurs with SLAVE_EN=1 and SLAVE_WE=0.
  - B_RESP=00.

Test Plan:
- RD_LAT=2: write 0xDEADBEEF to BASE+0x10 with strobe 0xF, then read it.
  - Required: SLAVE_ADDR=4 in both issue cycles.
  - Required: B_VALID one cycle after write issue; R_VALID exactly 3 cycles after read issue; R_DATA=0xDEADBEEF, R_RESP=00.
- W_VALID 3 cycles before AW_VALID, with strobe 0x3 and data 0x0000A5A5 at BASE+0x8.
  - Required: W_READY drops after the W handshake; a single issue occurs after the AW handshake with SLAVE_WE=0011.
- Write and read both eligible in the same cycle, repeated 4 times.
  - Required grants: W, R, W, R.
  - Required: no BRAM cycle carries both a write and a read.
- AR_ADDR = BASE+(DATA_W/8)*2^BRAM_ADDR_W.
  - Required: SLAVE_EN stays 0; R_RESP=10, R_DATA=0; ERR_COUNT=1.
  - Then 300 out-of-range writes. Required: ERR_COUNT=255.
- Hold B_READY low for 5 cycles, then send a second AW/W.
  - Required: B_VALID and B_RESP held; the second write is captured but not issued until the B handshake.
- Assert ARESETn low in the cycle after a read issue.
  - Required: no R_VALID follows; all outputs are at reset values; the first post-reset AR completes normally.
